// File: rtl/prbg_pattern_detector.sv
// Two seeded 4-bit Fibonacci LFSRs (x^4+x^3+1), a selectable 3-bit history
// shift register, and a masked pattern comparator with a registered match flag.
module prbg_pattern_detector (
  input  logic       clk,
  input  logic       res,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic       sel,
  input  logic [2:0] r1,
  input  logic [2:0] b1,
  input  logic [2:0] r2,
  input  logic [2:0] b2,
  output logic [2:0] shift_out,
  output logic       detect_out
);

  localparam int unsigned LfsrW = 4;
  localparam int unsigned ShW   = 3;
  localparam int unsigned CntW  = 2;
  localparam logic [CntW-1:0] CntFull = CntW'(3);

  logic [LfsrW-1:0] seed_a;
  logic [LfsrW-1:0] seed_b;
  logic [LfsrW-1:0] lfsr_a_q, lfsr_a_d;
  logic [LfsrW-1:0] lfsr_b_q, lfsr_b_d;
  logic [ShW-1:0]   shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             detect_q, detect_d;

  logic             sel_bit;
  logic [ShW-1:0]   pat;
  logic [ShW-1:0]   mask;
  logic             valid;
  logic             match;

  // All-zero seeds would lock the LFSR, so substitute 4'h1
  always_comb begin
    seed_a = (a_in == '0) ? LfsrW'(1) : a_in;
    seed_b = (b_in == '0) ? LfsrW'(1) : b_in;
  end

  // Next-state: advance both LFSRs, shift selected bit, fill count, detect
  always_comb begin
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    detect_d = 1'b0;
    sel_bit  = 1'b0;
    pat      = '0;
    mask     = '0;
    valid    = 1'b0;
    match    = 1'b0;

    lfsr_a_d = {lfsr_a_q[2:0], lfsr_a_q[3] ^ lfsr_a_q[2]};
    lfsr_b_d = {lfsr_b_q[2:0], lfsr_b_q[3] ^ lfsr_b_q[2]};

    sel_bit  = sel ? lfsr_b_q[3] : lfsr_a_q[3];
    shift_d  = {shift_q[1:0], sel_bit};

    if (cnt_q != CntFull) begin
      cnt_d = cnt_q + CntW'(1);
    end

    pat      = sel ? r2 : r1;
    mask     = sel ? b2 : b1;
    valid    = (cnt_q == CntFull);
    match    = (((shift_q ^ pat) & mask) == '0) && (mask != '0);
    detect_d = valid & match;
  end

  // State registers; reset reloads seeds and clears history and flag
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      lfsr_a_q <= seed_a;
      lfsr_b_q <= seed_b;
      shift_q  <= '0;
      cnt_q    <= '0;
      detect_q <= 1'b0;
    end else begin
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      detect_q <= detect_d;
    end
  end

  assign shift_out  = shift_q;
  assign detect_out = detect_q;

endmodule

// File: tb/tb_prbg_pattern_detector.sv
// Directed bench for prbg_pattern_detector with hand-computed expected streams.
module tb_prbg_pattern_detector;

  logic       clk;
  logic       res;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic       sel;
  logic [2:0] r1;
  logic [2:0] b1;
  logic [2:0] r2;
  logic [2:0] b2;
  logic [2:0] shift_out;
  logic       detect_out;

  int unsigned n_cmp;
  int unsigned n_err;

  prbg_pattern_detector dut (
    .clk       (clk),
    .res       (res),
    .a_in      (a_in),
    .b_in      (b_in),
    .sel       (sel),
    .r1        (r1),
    .b1        (b1),
    .r2        (r2),
    .b2        (b2),
    .shift_out (shift_out),
    .detect_out(detect_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report any mismatch
  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Hold reset for two edges, check reset values, then release after an edge
  task automatic do_reset();
    @(posedge clk); #1;
    res = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rst_shift", 8'(shift_out), 8'h0);
    check_eq("rst_detect", 8'(detect_out), 8'h0);
    res = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [2:0] exp_a_sh [9];
  logic [2:0] exp_b_sh [9];
  logic       exp_a_det[9];
  logic       exp_pm_det[9];

  initial begin
    n_cmp = 0;
    n_err = 0;
    res  = 1'b0;
    a_in = 4'hA;
    b_in = 4'h7;
    sel  = 1'b0;
    r1   = 3'd5;
    b1   = 3'b111;
    r2   = 3'd3;
    b2   = 3'd6;

    exp_a_sh   = '{3'b001, 3'b010, 3'b101, 3'b010, 3'b101, 3'b011, 3'b111, 3'b111, 3'b110};
    exp_b_sh   = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100, 3'b000, 3'b001};
    exp_a_det  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_pm_det = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Generator A stream with full-mask detection of 3'b101
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step();
      check_eq($sformatf("a_shift_e%0d", i + 1), 8'(shift_out), 8'(exp_a_sh[i]));
      check_eq($sformatf("a_det_e%0d", i + 1), 8'(detect_out), 8'(exp_a_det[i]));
    end

    // Asynchronous reset mid-stream clears outputs without an edge
    #2;
    res = 1'b0;
    #1;
    check_eq("async_shift", 8'(shift_out), 8'h0);
    check_eq("async_detect", 8'(detect_out), 8'h0);

    // Generator B stream; zero mask never detects
    sel = 1'b1;
    b2  = 3'b000;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step();
      check_eq($sformatf("b_shift_e%0d", i + 1), 8'(shift_out), 8'(exp_b_sh[i]));
      check_eq($sformatf("b_zmask_det_e%0d", i + 1), 8'(detect_out), 8'h0);
    end

    // Partial mask: only bit 1 compared, must be 0
    sel = 1'b0;
    r1  = 3'd5;
    b1  = 3'd2;
    exp_pm_det = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step();
      check_eq($sformatf("pmask_det_e%0d", i + 1), 8'(detect_out), 8'(exp_pm_det[i]));
    end

    // Zero seed on A behaves as seed 4'h1: stream 0,0,0,1,0,0,1,1
    a_in = 4'h0;
    b1   = 3'b111;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    check_eq("zseed_e3", 8'(shift_out), 8'h0);
    step();
    check_eq("zseed_e4", 8'(shift_out), 8'h1);
    step();
    check_eq("zseed_e5", 8'(shift_out), 8'h2);
    step();
    check_eq("zseed_e6", 8'(shift_out), 8'h4);
    step();
    check_eq("zseed_e7", 8'(shift_out), 8'h1);
    step();
    check_eq("zseed_e8", 8'(shift_out), 8'h3);

    // Mid-stream select switch from A to B after six edges
    a_in = 4'hA;
    b_in = 4'h7;
    r1   = 3'd5;
    b1   = 3'b111;
    r2   = 3'd3;
    b2   = 3'd6;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    check_eq("sw_shift_e6", 8'(shift_out), 8'h3);
    sel = 1'b1;
    step();
    check_eq("sw_shift_e7", 8'(shift_out), 8'h6);
    check_eq("sw_det_e7", 8'(detect_out), 8'h1);
    step();
    check_eq("sw_shift_e8", 8'(shift_out), 8'h4);
    check_eq("sw_det_e8", 8'(detect_out), 8'h0);
    step();
    check_eq("sw_shift_e9", 8'(shift_out), 8'h1);
    check_eq("sw_det_e9", 8'(detect_out), 8'h0);
    step();
    check_eq("sw_shift_e10", 8'(shift_out), 8'h2);
    check_eq("sw_det_e10", 8'(detect_out), 8'h0);
    step();
    check_eq("sw_det_e11", 8'(detect_out), 8'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
